// File: rtl/tlp_pattern_gen_chk.sv
// TLP pattern generator and sequence checker for full-rate link exercise; one instance per direction.
// Define TLP_PATTERN_INJECT_EN to add i_inject, which corrupts bit 0 of the next written word.
module tlp_pattern_gen_chk #(
  parameter int unsigned TX_WIDTH    = 56,
  parameter int unsigned RX_WIDTH    = 56,
  parameter int unsigned CNT_WIDTH   = 32,
  parameter int unsigned LOSS_THRESH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_arst_n,
  input  logic                 i_gen_en,
  input  logic                 i_chk_en,
  input  logic                 i_clear,
`ifdef TLP_PATTERN_INJECT_EN
  input  logic                 i_inject,
`endif
  input  logic                 i_tlp_rdy,
  output logic                 o_tlp_wr,
  output logic [TX_WIDTH-1:0]  o_tlp,
  input  logic                 i_tlp_valid,
  input  logic [RX_WIDTH-1:0]  i_tlp,
  output logic                 o_tlp_rd,
  output logic [CNT_WIDTH-1:0] o_tx_cnt,
  output logic [CNT_WIDTH-1:0] o_rx_cnt,
  output logic [CNT_WIDTH-1:0] o_err_cnt,
  output logic                 o_locked,
  output logic                 o_err_pls
);

  typedef enum logic [1:0] {StIdle, StHunt, StLocked} chk_state_e;

  // Low 32 bits carry n; upper bits repeat ~n from bit 0 upward.
  function automatic logic [TX_WIDTH-1:0] pat_tx(input logic [31:0] n);
    logic [TX_WIDTH-1:0] w;
    for (int i = 0; i < TX_WIDTH; i++) begin
      w[i] = (i < 32) ? n[i[4:0]] : ~n[i[4:0]];
    end
    return w;
  endfunction

  function automatic logic [RX_WIDTH-1:0] pat_rx(input logic [31:0] n);
    logic [RX_WIDTH-1:0] w;
    for (int i = 0; i < RX_WIDTH; i++) begin
      w[i] = (i < 32) ? n[i[4:0]] : ~n[i[4:0]];
    end
    return w;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c);
    return (&c) ? c : c + CNT_WIDTH'(1);
  endfunction

  // ---------------- Generator ----------------
  logic                 tlp_wr;
  logic [31:0]          tx_seq_q, tx_seq_d;
  logic [TX_WIDTH-1:0]  tlp_q, tlp_d;
  logic [CNT_WIDTH-1:0] tx_cnt_q, tx_cnt_d;

  // Gated by reset so the write strobe stays low while reset is held.
  assign tlp_wr   = i_gen_en & i_tlp_rdy & i_arst_n;
  assign o_tlp_wr = tlp_wr;
  assign o_tx_cnt = tx_cnt_q;

  always_comb begin
    tx_seq_d = tx_seq_q;
    tlp_d    = tlp_q;
    tx_cnt_d = tx_cnt_q;
    if (i_clear) begin
      tx_seq_d = '0;
      tlp_d    = pat_tx(32'd0);
      tx_cnt_d = '0;
    end else if (tlp_wr) begin
      tx_seq_d = tx_seq_q + 32'd1;
      tlp_d    = pat_tx(tx_seq_q + 32'd1);
      tx_cnt_d = sat_inc(tx_cnt_q);
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      tx_seq_q <= '0;
      tlp_q    <= pat_tx(32'd0);
      tx_cnt_q <= '0;
    end else begin
      tx_seq_q <= tx_seq_d;
      tlp_q    <= tlp_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

`ifdef TLP_PATTERN_INJECT_EN
  logic inject_q;
  logic armed_q, armed_d;

  // Arm on a rising edge; disarm once the corrupted word has been written.
  assign armed_d = (armed_q & ~tlp_wr) | (i_inject & ~inject_q);
  assign o_tlp   = {tlp_q[TX_WIDTH-1:1], tlp_q[0] ^ armed_q};

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      inject_q <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      inject_q <= i_inject;
      armed_q  <= armed_d;
    end
  end
`else
  assign o_tlp = tlp_q;
`endif

  // ---------------- Checker ----------------
  chk_state_e           state_q, state_d;
  logic [31:0]          exp_q, exp_d;
  logic [3:0]           run_q, run_d, run_inc;
  logic [CNT_WIDTH-1:0] rx_cnt_q, rx_cnt_d, err_cnt_q, err_cnt_d;
  logic                 err_pls_q, err_pls_d, locked_q, locked_d;
  logic                 tlp_rd, word_match, word_consistent;
  logic [31:0]          rx_low;

  assign tlp_rd          = i_tlp_valid & (state_q != StIdle);
  assign o_tlp_rd        = tlp_rd;
  assign rx_low          = i_tlp[31:0];
  assign word_match      = (i_tlp == pat_rx(exp_q));
  assign word_consistent = (i_tlp == pat_rx(rx_low));
  assign run_inc         = run_q + 4'd1;

  assign o_rx_cnt  = rx_cnt_q;
  assign o_err_cnt = err_cnt_q;
  assign o_locked  = locked_q;
  assign o_err_pls = err_pls_q;

  always_comb begin
    state_d   = state_q;
    exp_d     = exp_q;
    run_d     = run_q;
    rx_cnt_d  = rx_cnt_q;
    err_cnt_d = err_cnt_q;
    err_pls_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_chk_en) state_d = StHunt;
      end
      StHunt: begin
        if (tlp_rd) begin
          rx_cnt_d = sat_inc(rx_cnt_q);
          if (word_consistent) begin
            exp_d   = rx_low + 32'd1;
            run_d   = '0;
            state_d = StLocked;
          end
        end
      end
      StLocked: begin
        if (tlp_rd) begin
          rx_cnt_d = sat_inc(rx_cnt_q);
          if (word_match) begin
            exp_d = exp_q + 32'd1;
            run_d = '0;
          end else begin
            // Resync on the received word so a single drop costs one error.
            err_cnt_d = sat_inc(err_cnt_q);
            err_pls_d = 1'b1;
            exp_d     = rx_low + 32'd1;
            run_d     = run_inc;
            if (run_inc >= 4'(LOSS_THRESH)) begin
              state_d = StHunt;
              run_d   = '0;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
    if (!i_chk_en) state_d = StIdle;
    if (i_clear) begin
      rx_cnt_d  = '0;
      err_cnt_d = '0;
      err_pls_d = 1'b0;
      run_d     = '0;
      exp_d     = '0;
      state_d   = i_chk_en ? StHunt : StIdle;
    end
    locked_d = (state_d == StLocked);
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q   <= StIdle;
      exp_q     <= '0;
      run_q     <= '0;
      rx_cnt_q  <= '0;
      err_cnt_q <= '0;
      err_pls_q <= 1'b0;
      locked_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      exp_q     <= exp_d;
      run_q     <= run_d;
      rx_cnt_q  <= rx_cnt_d;
      err_cnt_q <= err_cnt_d;
      err_pls_q <= err_pls_d;
      locked_q  <= locked_d;
    end
  end

endmodule

// File: tb/tb_tlp_pattern_gen_chk.sv
// Directed, table-driven bench for tlp_pattern_gen_chk (default parameters, 56-bit words).
module tb_tlp_pattern_gen_chk;

  logic        clk = 1'b0;
  logic        arst_n;
  logic        gen_en, chk_en, clear, tlp_rdy, tlp_valid;
  logic        tlp_wr, tlp_rd, locked, err_pls;
  logic [55:0] tlp_out, tlp_in;
  logic [31:0] tx_cnt, rx_cnt, err_cnt;
`ifdef TLP_PATTERN_INJECT_EN
  logic        inject = 1'b0;
`endif

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  tlp_pattern_gen_chk dut (
    .i_clk       (clk),
    .i_arst_n    (arst_n),
    .i_gen_en    (gen_en),
    .i_chk_en    (chk_en),
    .i_clear     (clear),
`ifdef TLP_PATTERN_INJECT_EN
    .i_inject    (inject),
`endif
    .i_tlp_rdy   (tlp_rdy),
    .o_tlp_wr    (tlp_wr),
    .o_tlp       (tlp_out),
    .i_tlp_valid (tlp_valid),
    .i_tlp       (tlp_in),
    .o_tlp_rd    (tlp_rd),
    .o_tx_cnt    (tx_cnt),
    .o_rx_cnt    (rx_cnt),
    .o_err_cnt   (err_cnt),
    .o_locked    (locked),
    .o_err_pls   (err_pls)
  );

  // Reference pattern: {~n, ~n, n} truncated to 56 bits.
  function automatic logic [55:0] pat(input logic [31:0] n);
    logic [95:0] x;
    x = {~n, ~n, n};
    return x[55:0];
  endfunction

  function automatic logic [55:0] garbage(input logic [31:0] n);
    logic [55:0] w;
    w = pat(n);
    w[40] = ~w[40];
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        gen;
    logic        rdy;
    logic        wr;
    logic [31:0] seq;
    int unsigned cnt;
  } gen_vec_t;

  typedef struct {
    logic        valid;
    logic [55:0] word;
    logic        rd;
    logic        lck;
    logic        pls;
    int unsigned rx;
    int unsigned err;
  } chk_vec_t;

  gen_vec_t gv[11];
  chk_vec_t cv[14];

  initial begin
    // {gen_en, rdy, expected wr, expected current word seq, tx_cnt after edge}
    gv[0]  = '{1'b1, 1'b1, 1'b1, 32'd0, 1};
    gv[1]  = '{1'b1, 1'b1, 1'b1, 32'd1, 2};
    gv[2]  = '{1'b1, 1'b1, 1'b1, 32'd2, 3};
    gv[3]  = '{1'b1, 1'b1, 1'b1, 32'd3, 4};
    gv[4]  = '{1'b1, 1'b1, 1'b1, 32'd4, 5};
    gv[5]  = '{1'b1, 1'b0, 1'b0, 32'd5, 5};
    gv[6]  = '{1'b1, 1'b1, 1'b1, 32'd5, 6};
    gv[7]  = '{1'b1, 1'b0, 1'b0, 32'd6, 6};
    gv[8]  = '{1'b1, 1'b1, 1'b1, 32'd6, 7};
    gv[9]  = '{1'b0, 1'b1, 1'b0, 32'd7, 7};
    gv[10] = '{1'b0, 1'b0, 1'b0, 32'd7, 7};

    // {valid, word, rd, locked after, err_pls after, rx_cnt after, err_cnt after}
    cv[0]  = '{1'b1, pat(100),     1'b1, 1'b1, 1'b0, 1,  0};
    cv[1]  = '{1'b1, pat(101),     1'b1, 1'b1, 1'b0, 2,  0};
    cv[2]  = '{1'b1, pat(102),     1'b1, 1'b1, 1'b0, 3,  0};
    cv[3]  = '{1'b1, pat(104),     1'b1, 1'b1, 1'b1, 4,  1}; // 103 dropped
    cv[4]  = '{1'b1, pat(105),     1'b1, 1'b1, 1'b0, 5,  1};
    cv[5]  = '{1'b0, pat(106),     1'b0, 1'b1, 1'b0, 5,  1};
    cv[6]  = '{1'b1, garbage(300), 1'b1, 1'b1, 1'b1, 6,  2};
    cv[7]  = '{1'b1, garbage(301), 1'b1, 1'b1, 1'b1, 7,  3};
    cv[8]  = '{1'b1, garbage(302), 1'b1, 1'b1, 1'b1, 8,  4};
    cv[9]  = '{1'b1, garbage(303), 1'b1, 1'b0, 1'b1, 9,  5};
    cv[10] = '{1'b1, garbage(304), 1'b1, 1'b0, 1'b0, 10, 5};
    cv[11] = '{1'b1, pat(500),     1'b1, 1'b1, 1'b0, 11, 5};
    cv[12] = '{1'b1, pat(501),     1'b1, 1'b1, 1'b0, 12, 5};
    cv[13] = '{1'b1, pat(502),     1'b1, 1'b1, 1'b0, 13, 5};

    arst_n = 1'b0; gen_en = 1'b0; chk_en = 1'b0; clear = 1'b0;
    tlp_rdy = 1'b0; tlp_valid = 1'b0; tlp_in = '0;
    #12;
    chk("rst tlp", tlp_out, pat(0));
    chk("rst tx_cnt", tx_cnt, 0);
    chk("rst rx_cnt", rx_cnt, 0);
    chk("rst err_cnt", err_cnt, 0);
    chk("rst locked", locked, 0);
    chk("rst err_pls", err_pls, 0);
    @(negedge clk);
    arst_n = 1'b1;
    cyc();

    for (int i = 0; i < 11; i++) begin
      gen_en = gv[i].gen; tlp_rdy = gv[i].rdy;
      #1;
      chk($sformatf("gen[%0d] wr", i), tlp_wr, gv[i].wr);
      chk($sformatf("gen[%0d] tlp", i), tlp_out, pat(gv[i].seq));
      cyc();
      chk($sformatf("gen[%0d] tx_cnt", i), tx_cnt, gv[i].cnt);
    end

    chk_en = 1'b1;
    cyc();
    chk("hunt locked", locked, 0);
    for (int i = 0; i < 14; i++) begin
      tlp_valid = cv[i].valid; tlp_in = cv[i].word;
      #1;
      chk($sformatf("chk[%0d] rd", i), tlp_rd, cv[i].rd);
      cyc();
      chk($sformatf("chk[%0d] locked", i), locked, cv[i].lck);
      chk($sformatf("chk[%0d] err_pls", i), err_pls, cv[i].pls);
      chk($sformatf("chk[%0d] rx_cnt", i), rx_cnt, cv[i].rx);
      chk($sformatf("chk[%0d] err_cnt", i), err_cnt, cv[i].err);
    end

    // Clear while writing and popping: strobes fire, counters do not advance.
    gen_en = 1'b1; tlp_rdy = 1'b1; tlp_valid = 1'b1; tlp_in = pat(503); clear = 1'b1;
    #1;
    chk("clear wr", tlp_wr, 1);
    chk("clear rd", tlp_rd, 1);
    cyc();
    clear = 1'b0; gen_en = 1'b0; tlp_valid = 1'b0;
    chk("clear tx_cnt", tx_cnt, 0);
    chk("clear rx_cnt", rx_cnt, 0);
    chk("clear err_cnt", err_cnt, 0);
    chk("clear locked", locked, 0);
    chk("clear tlp", tlp_out, pat(0));
    gen_en = 1'b1;
    #1;
    chk("post-clear tlp0", tlp_out, pat(0));
    cyc();
    gen_en = 1'b0;
    chk("post-clear tx_cnt", tx_cnt, 1);
    chk("post-clear tlp1", tlp_out, pat(1));

    // Sequence wrap across 0xFFFFFFFF -> 0.
    begin
      logic [31:0] s;
      s = 32'hFFFF_FFFE;
      for (int i = 0; i < 4; i++) begin
        tlp_valid = 1'b1; tlp_in = pat(s);
        cyc();
        chk($sformatf("wrap[%0d] locked", i), locked, 1);
        chk($sformatf("wrap[%0d] err_pls", i), err_pls, 0);
        s = s + 32'd1;
      end
      tlp_valid = 1'b0;
      chk("wrap rx_cnt", rx_cnt, 4);
      chk("wrap err_cnt", err_cnt, 0);
    end

    // Disable checker: back to idle, pops stop.
    chk_en = 1'b0;
    cyc();
    tlp_valid = 1'b1; tlp_in = pat(2);
    #1;
    chk("idle locked", locked, 0);
    chk("idle rd", tlp_rd, 0);
    cyc();
    chk("idle rx_cnt", rx_cnt, 4);

    // Asynchronous reset mid-operation.
    chk_en = 1'b1; gen_en = 1'b1; tlp_rdy = 1'b1;
    cyc();
    cyc();
    #2;
    arst_n = 1'b0;
    #1;
    chk("arst wr", tlp_wr, 0);
    chk("arst rd", tlp_rd, 0);
    chk("arst tx_cnt", tx_cnt, 0);
    chk("arst rx_cnt", rx_cnt, 0);
    chk("arst locked", locked, 0);
    chk("arst tlp", tlp_out, pat(0));
    @(negedge clk);
    arst_n = 1'b1;
    gen_en = 1'b0; chk_en = 1'b0; tlp_valid = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
